// File: rtl/integer_alu_pkg.sv
// Shared opcode constants, the decoded operation enum and the opcode decoder
// for the integer ALU.
package integer_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    // funct3 groups whose alt bit selects between two operations
    localparam logic [2:0] F3_ADDSUB = OP_ADD[3:1];
    localparam logic [2:0] F3_SHR    = OP_SRL[3:1];

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd
    } alu_op_t;

    function automatic alu_op_t decode_op(logic [3:0] opcode);
        alu_op_t op;
        case (opcode[3:1])
            F3_ADDSUB: op = (opcode == OP_SUB) ? AluSub : AluAdd;
            OP_SLL:    op = AluSll;
            OP_SLT:    op = AluSlt;
            OP_SLTU:   op = AluSltu;
            OP_XOR:    op = AluXor;
            F3_SHR:    op = (opcode == OP_SRA) ? AluSra : AluSrl;
            OP_OR:     op = AluOr;
            OP_AND:    op = AluAnd;
            default:   op = AluAdd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/integer_alu_shifter.sv
// Combinational log2-stage barrel shifter for SLL/SRL/SRA. Left shifts are
// performed as right shifts on the bit-reversed operand.
module integer_alu_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic             dir_i,    // 1: right, 0: left
    input  logic             arith_i,  // sign fill, right shifts only
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_rev;
    logic [WIDTH-1:0] out_rev;
    logic             fill;
    logic [WIDTH-1:0] stage [SHW+1];

    always_comb begin
        data_rev = '0;
        out_rev  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            data_rev[i] = data_i[WIDTH-1-i];
            out_rev[i]  = stage[SHW][WIDTH-1-i];
        end
    end

    assign fill     = arith_i & dir_i & data_i[WIDTH-1];
    assign stage[0] = dir_i ? data_i : data_rev;

    for (genvar s = 0; s < int'(SHW); s++) begin : g_stage
        localparam int unsigned Step = 2 ** s;
        assign stage[s+1] = shamt_i[s] ? {{Step{fill}}, stage[s][WIDTH-1:Step]} : stage[s];
    end

    assign data_o = dir_i ? stage[SHW] : out_rev;

endmodule

// File: rtl/integer_alu.sv
// Single-cycle registered RV32I/RV64I integer ALU: add/sub, shifts, compares
// and bitwise logic, result presented one clock after issue.
module integer_alu
    import integer_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             valid_out
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_op_t          op;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             lt_signed;
    logic             lt_unsigned;
    logic             shift_right;
    logic             shift_arith;
    logic [WIDTH-1:0] shift_res;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] y_d, y_q;
    logic             valid_d, valid_q;

    assign op = decode_op(opcode);

    // Compares share the subtractor: A + ~B + 1
    assign is_sub = (op == AluSub) || (op == AluSlt) || (op == AluSltu);
    assign b_eff  = is_sub ? ~B : B;
    assign sum    = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

    // Carry out of A + ~B + 1 is set exactly when A >= B unsigned
    assign lt_unsigned = ~sum[WIDTH];
    assign lt_signed   = (A[WIDTH-1] != B[WIDTH-1]) ? A[WIDTH-1] : sum[WIDTH-1];

    assign shift_right = (op == AluSrl) || (op == AluSra);
    assign shift_arith = (op == AluSra);

    integer_alu_shifter #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_shifter (
        .data_i (A),
        .shamt_i(B[SHW-1:0]),
        .dir_i  (shift_right),
        .arith_i(shift_arith),
        .data_o (shift_res)
    );

    always_comb begin
        result = '0;
        unique case (op)
            AluAdd, AluSub:         result = sum[WIDTH-1:0];
            AluSll, AluSrl, AluSra: result = shift_res;
            AluSlt:                 result = {{(WIDTH-1){1'b0}}, lt_signed};
            AluSltu:                result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            AluXor:                 result = A ^ B;
            AluOr:                  result = A | B;
            AluAnd:                 result = A & B;
            default:                result = '0;
        endcase
    end

    // Idle cycles hold Y so undriven operands never reach the output
    always_comb begin
        y_d     = y_q;
        valid_d = 1'b0;
        if (valid_in) begin
            y_d     = result;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign Y         = y_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_integer_alu.sv
// Self-checking bench for integer_alu: directed literal cases plus a random
// sweep checked every cycle against a behavioural model.
module tb_integer_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] Y;
    logic        valid_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_y = 32'd0;
    logic        exp_v = 1'b0;

    integer_alu #(
        .WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .opcode   (opcode),
        .A        (A),
        .B        (B),
        .Y        (Y),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op[3:1])
            3'b000:  return op[0] ? a - b : a + b;
            3'b001:  return a << sh;
            3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  return (a < b) ? 32'd1 : 32'd0;
            3'b100:  return a ^ b;
            3'b101:  return op[0] ? 32'($signed(a) >>> sh) : a >> sh;
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_y <= 32'd0;
            exp_v <= 1'b0;
        end else begin
            exp_v <= valid_in;
            if (valid_in) exp_y <= ref_alu(opcode, A, B);
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if (Y !== exp_y || valid_out !== exp_v) begin
            n_bad++;
            $display("FAIL model t=%0t: got Y=%h valid_out=%b, expected Y=%h valid_out=%b",
                     $time, Y, valid_out, exp_y, exp_v);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        valid_in = v;
        opcode   = op;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic op_chk(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want);
        step(1'b1, op, a, b);
        chk(name, Y, want);
        chk({name, " valid"}, {31'd0, valid_out}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset Y", Y, 32'd0);
        chk("reset valid", {31'd0, valid_out}, 32'd0);
        rst_n = 1'b1;

        // back-to-back ADD then SUB, then hold
        op_chk("add wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
        op_chk("sub underflow", 4'b0001, 32'd0, 32'd1, 32'hFFFF_FFFF);
        step(1'b0, 4'($urandom), $urandom, $urandom);
        chk("hold Y", Y, 32'hFFFF_FFFF);
        chk("hold valid", {31'd0, valid_out}, 32'd0);

        op_chk("slt neg", 4'b0100, 32'h8000_0000, 32'd1, 32'd1);
        op_chk("slt alt", 4'b0101, 32'h8000_0000, 32'd1, 32'd1);
        op_chk("sltu big", 4'b0110, 32'h8000_0000, 32'd1, 32'd0);
        op_chk("slt eq", 4'b0100, 32'h1234, 32'h1234, 32'd0);
        op_chk("sltu eq", 4'b0111, 32'h1234, 32'h1234, 32'd0);

        op_chk("sra", 4'b1011, 32'h8000_0000, 32'h21, 32'hC000_0000);
        op_chk("srl", 4'b1010, 32'h8000_0000, 32'h21, 32'h4000_0000);
        op_chk("sll shamt0", 4'b0010, 32'h8000_0000, 32'h20, 32'h8000_0000);
        op_chk("sll 31", 4'b0011, 32'd1, 32'd31, 32'h8000_0000);

        op_chk("xor", 4'b1000, 32'h0F0F_00FF, 32'h00FF_0F0F, 32'h0FF0_0FF0);
        op_chk("xor alt", 4'b1001, 32'h0F0F_00FF, 32'h00FF_0F0F, 32'h0FF0_0FF0);
        op_chk("or", 4'b1100, 32'h0F0F_00FF, 32'h00FF_0F0F, 32'h0FFF_0FFF);
        op_chk("or alt", 4'b1101, 32'h0F0F_00FF, 32'h00FF_0F0F, 32'h0FFF_0FFF);
        op_chk("and", 4'b1110, 32'h0F0F_00FF, 32'h00FF_0F0F, 32'h000F_000F);
        op_chk("and alt", 4'b1111, 32'h0F0F_00FF, 32'h00FF_0F0F, 32'h000F_000F);

        // asynchronous reset between edges
        op_chk("pre-reset add", 4'b0000, 32'd5, 32'd7, 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset Y", Y, 32'd0);
        chk("async reset valid", {31'd0, valid_out}, 32'd0);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op_chk("post-reset sub", 4'b0001, 32'd10, 32'd3, 32'd7);

        // random sweep, occasionally idle, shift amounts sometimes beyond 31
        for (int op = 0; op < 16; op++) begin
            for (int n = 0; n < 1000; n++) begin
                logic [31:0] b;
                b = $urandom;
                if ($urandom_range(0, 1) == 0) b = $urandom_range(0, 70);
                step($urandom_range(0, 9) != 0, 4'(op), $urandom, b);
            end
        end

        step(1'b0, 4'd0, 32'd0, 32'd0);
        step(1'b0, 4'd0, 32'd0, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/integer_alu.md
Name: integer_alu

Overview:
- Single-cycle registered integer ALU for the RV32I/RV64I execute stage.
- Opcode is the RISC-V {funct3, funct7[5]} concatenation: opcode[3:1]=funct3, opcode[0]=alt bit.
- Computes add/sub, shifts, signed/unsigned compare and bitwise logic on two WIDTH-bit operands.
- Presents the result on a registered output one clock after issue.

Parameters:
- WIDTH, 32, operand/result width. Must be a power of two and at least 8. Shift amount width is SHW = clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- valid_in  input  1  opcode/A/B are valid this cycle; launch an operation
- opcode  input  4  operation select, {funct3, alt}
- A  input  WIDTH  operand A (rs1)
- B  input  WIDTH  operand B (rs2/imm); for shifts only B[SHW-1:0] is used
- Y  output  WIDTH  registered result
- valid_out  output  1  Y holds the result of the operation launched the previous cycle

Behaviour:
- Reset: while rst_n=0, Y=0 and valid_out=0 immediately (asynchronous). Release is synchronous to the next clk edge. An operation in flight when reset asserts is discarded.
- Latency: exactly 1 cycle. The result of inputs sampled at edge N appears on Y after edge N, with valid_out=1.
- Throughput: one operation per cycle; back-to-back valid_in is allowed. There is no stall or backpressure.
- valid_in=0 at an edge: Y holds its previous value; valid_out goes to 0.
- Opcode map (x = don't care; opcode[0] is ignored unless listed):
  - 0000 ADD: Y = A+B mod 2^WIDTH.
  - 0001 SUB: Y = A-B mod 2^WIDTH.
  - 001x SLL: Y = A << B[SHW-1:0], zero fill.
  - 010x SLT: Y = 1 if signed(A) < signed(B), else 0; upper WIDTH-1 bits are zero.
  - 011x SLTU: Y = 1 if unsigned(A) < unsigned(B), else 0; upper bits zero.
  - 100x XOR: Y = A^B.
  - 1010 SRL: Y = A >> shamt, zero fill.
  - 1011 SRA: Y = A >> shamt, filled with A[WIDTH-1].
  - 110x OR: Y = A|B.
  - 111x AND: Y = A&B.
- Arithmetic rules:
  - No carry, overflow or flag outputs; overflow silently wraps.
  - Shift amount bits of B above SHW-1 are ignored (B=WIDTH acts as a shift by 0).
  - A shift amount of 0 returns A unchanged.
  - SLT/SLTU with A==B returns 0.
- All 16 opcodes are defined; there is no illegal-opcode behaviour.
- X/Z on the inputs while valid_in=0 must not affect Y.

Decomposition:
- Package integer_alu_pkg:
  - opcode localparams: OP_ADD=4'b0000, OP_SUB=4'b0001, OP_SLL=3'b001, OP_SLT=3'b010, OP_SLTU=3'b011, OP_XOR=3'b100, OP_SRL=4'b1010, OP_SRA=4'b1011, OP_OR=3'b110, OP_AND=3'b111 (3-bit constants compare against opcode[3:1]);
  - enum typedef alu_op_t for waveform readability.
- One sub-module, integer_alu_shifter: combinational barrel shifter covering SLL/SRL/SRA with log2 stages; inputs data, shamt, dir, arith.
- Adder/subtractor and comparators stay inline. SLT/SLTU reuse the subtractor borrow/sign.

Test Plan:
- ADD wrap / SUB underflow: A=0xFFFFFFFF, B=1, op 0000 -> Y=0x00000000 next cycle, valid_out=1. A=0, B=1, op 0001 -> Y=0xFFFFFFFF.
- Signed vs unsigned compare: A=0x80000000, B=0x00000001. Op 010x -> Y=1; op 011x -> Y=0. A=B=0x1234 with either op -> Y=0.
- Shifts, A=0x80000000:
  - op 1011, B=0x21 -> Y=0xC0000000;
  - op 1010, same B -> Y=0x40000000;
  - op 0010, B=0x20 -> Y=0x80000000 (shamt 0);
  - op 0011, A=1, B=31 -> Y=0x80000000.
- Logic, opcode[0] ignored: A=0x0F0F00FF, B=0x00FF0F0F. Op 1000/1001 -> 0x0FF00FF0; op 1100/1101 -> 0x0FFF0FFF; op 1110/1111 -> 0x000F000F.
- Pipeline/hold: issue ADD then SUB on consecutive cycles -> results on consecutive cycles. Then valid_in=0 with random inputs -> Y holds the SUB result and valid_out=0.
- Async reset mid-operation: issue ADD, drop rst_n between edges -> Y=0 and valid_out=0 immediately without a clock. After release, the first valid op produces a correct result one cycle later.
- Random sweep: 1000 random A/B for every opcode 0..15, compared against a reference model.
